// File: rtl/qpd_trigger_requester.sv
// qpd_trigger_requester
// Initiator side of the quarter-period-delay trigger handshake. A host
// command (quarter-period count + repeat count) is turned into a series of
// ARM windows toward the delay block. Each window is preceded by a GAP so the
// delay block always sees a value change. The returned trigger edges are
// collected, and the block reports count, latency, timeout, abort and
// completion.
//
// Optional build macro QPD_REQ_TSTAMP_EN: adds a free-running 32-bit
// wrap-around counter and a trig_tstamp output. trig_tstamp latches that
// counter on every counted trigger edge.

module qpd_trigger_requester #(
    parameter int unsigned SAMPLE_FREQUENCY = 100000,
    parameter int unsigned TIMEOUT_CYCLES   = 262144,
    parameter int unsigned GAP_CYCLES       = 2
) (
    input  logic        sclock,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_count_qp,
    input  logic [7:0]  cmd_repeat,
    input  logic        abort,
    output logic        rt,
    output logic [15:0] count_quater_period,
    input  logic        trigger,
    output logic        busy,
    output logic        done,
    output logic        bad_cmd,
    output logic        timeout_err,
    output logic        aborted,
    output logic [7:0]  trig_count,
`ifdef QPD_REQ_TSTAMP_EN
    output logic [31:0] last_latency,
    output logic [31:0] trig_tstamp
`else
    output logic [31:0] last_latency
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        ARM  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] GapLast     = 32'(GAP_CYCLES - 1);

    // Elaboration-time sanity checks on the configuration
    if (TIMEOUT_CYCLES < 2) begin : gTimeoutCheck
        $error("TIMEOUT_CYCLES must be at least 2");
    end
    if (GAP_CYCLES < 1) begin : gGapCheck
        $error("GAP_CYCLES must be at least 1");
    end
    if (SAMPLE_FREQUENCY == 0) begin : gFreqCheck
        $error("SAMPLE_FREQUENCY must be non-zero");
    end

    state_t      state_q;
    logic        trigger_q;
    logic [31:0] timer_q;
    logic [31:0] timer_d;
    logic [31:0] gapCnt_q;
    logic [15:0] countQp_q;
    logic [7:0]  repeat_q;
    logic [7:0]  trigCount_q;
    logic [7:0]  trigCount_d;
    logic [31:0] lastLatency_q;
    logic        rt_q;
    logic [15:0] countOut_q;
    logic        busy_q;
    logic        cmdReady_q;
    logic        done_q;
    logic        badCmd_q;
    logic        timeoutErr_q;
    logic        aborted_q;

    logic        trigEdge;
    logic        countedEdge;
    logic        lastTrigger;

    // Edge detect, saturating timer / trigger counter and the "count this
    // edge" qualifier. Abort in the same cycle discards the edge.
    always_comb begin
        trigEdge    = trigger & ~trigger_q;
        countedEdge = (state_q == ARM) && trigEdge && !abort;
        timer_d     = (timer_q == 32'hFFFF_FFFF) ? timer_q : timer_q + 32'd1;
        trigCount_d = (trigCount_q == 8'hFF) ? trigCount_q : trigCount_q + 8'd1;
        lastTrigger = (trigCount_d == repeat_q);
    end

    // Main sequencer: state, handshake outputs and all status registers
    always_ff @(posedge sclock or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            trigger_q     <= 1'b0;
            timer_q       <= 32'd0;
            gapCnt_q      <= 32'd0;
            countQp_q     <= 16'd0;
            repeat_q      <= 8'd0;
            trigCount_q   <= 8'd0;
            lastLatency_q <= 32'd0;
            rt_q          <= 1'b0;
            countOut_q    <= 16'd0;
            busy_q        <= 1'b0;
            cmdReady_q    <= 1'b1;
            done_q        <= 1'b0;
            badCmd_q      <= 1'b0;
            timeoutErr_q  <= 1'b0;
            aborted_q     <= 1'b0;
        end else begin
            trigger_q <= trigger;
            done_q    <= 1'b0;
            badCmd_q  <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_count_qp == 16'd0) begin
                            badCmd_q <= 1'b1;
                        end else begin
                            countQp_q    <= cmd_count_qp;
                            repeat_q     <= (cmd_repeat == 8'd0) ? 8'd1 : cmd_repeat;
                            trigCount_q  <= 8'd0;
                            timeoutErr_q <= 1'b0;
                            aborted_q    <= 1'b0;
                            gapCnt_q     <= 32'd0;
                            busy_q       <= 1'b1;
                            cmdReady_q   <= 1'b0;
                            state_q      <= GAP;
                        end
                    end
                end

                GAP: begin
                    if (abort) begin
                        aborted_q <= 1'b1;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end else if (gapCnt_q >= GapLast) begin
                        rt_q       <= 1'b1;
                        countOut_q <= countQp_q;
                        timer_q    <= 32'd0;
                        state_q    <= ARM;
                    end else begin
                        gapCnt_q <= gapCnt_q + 32'd1;
                    end
                end

                ARM: begin
                    if (abort) begin
                        aborted_q  <= 1'b1;
                        rt_q       <= 1'b0;
                        countOut_q <= 16'd0;
                        done_q     <= 1'b1;
                        state_q    <= DONE;
                    end else if (countedEdge) begin
                        lastLatency_q <= timer_q;
                        trigCount_q   <= trigCount_d;
                        rt_q          <= 1'b0;
                        countOut_q    <= 16'd0;
                        if (lastTrigger) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            gapCnt_q <= 32'd0;
                            state_q  <= GAP;
                        end
                    end else if (timer_q == TimeoutLast) begin
                        timeoutErr_q <= 1'b1;
                        rt_q         <= 1'b0;
                        countOut_q   <= 16'd0;
                        done_q       <= 1'b1;
                        state_q      <= DONE;
                    end else begin
                        timer_q <= timer_d;
                    end
                end

                DONE: begin
                    busy_q     <= 1'b0;
                    cmdReady_q <= 1'b1;
                    state_q    <= IDLE;
                end

                default: begin
                    rt_q       <= 1'b0;
                    countOut_q <= 16'd0;
                    busy_q     <= 1'b0;
                    cmdReady_q <= 1'b1;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

`ifdef QPD_REQ_TSTAMP_EN
    logic [31:0] tstampCnt_q;
    logic [31:0] trigTstamp_q;

    // Free-running timestamp, captured on every counted trigger edge
    always_ff @(posedge sclock or negedge rst_n) begin
        if (!rst_n) begin
            tstampCnt_q  <= 32'd0;
            trigTstamp_q <= 32'd0;
        end else begin
            tstampCnt_q <= tstampCnt_q + 32'd1;
            if (countedEdge) begin
                trigTstamp_q <= tstampCnt_q;
            end
        end
    end

    assign trig_tstamp = trigTstamp_q;
`endif

    assign cmd_ready           = cmdReady_q;
    assign rt                  = rt_q;
    assign count_quater_period = countOut_q;
    assign busy                = busy_q;
    assign done                = done_q;
    assign bad_cmd             = badCmd_q;
    assign timeout_err         = timeoutErr_q;
    assign aborted             = aborted_q;
    assign trig_count          = trigCount_q;
    assign last_latency        = lastLatency_q;

endmodule
